uart_rx: RTL and testbench

Receive half of the display controller's 8N1 serial link. Deserialises the `rxi` line into `bitwidth`-bit words, using the same `divisor` baud convention as the transmit side: `divisor` clk cycles per bit. Each received word is presented for exactly one cycle with a `valid` strobe. A missing stop bit is reported as a framing error, and the block then waits out a break before it accepts another frame.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync.sv | 29 ++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the display controller's serial link.
package uart_pkg;

  typedef enum logic [2:0] {
    ARM   = 3'd0,
    IDLE  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_rx_state_t;

  // Mid-bit offset used to centre the start-bit sample.
  function automatic int unsigned uart_half(input int unsigned divisor);
    return divisor / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
  parameter int unsigned depth   = 2,
  parameter logic        rst_val = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (depth < 2) begin : g_depth_check
    $error("uart_sync: depth must be at least 2");
  end

  logic [depth-1:0] ff;

  // Shift chain; reset to the line's idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= {depth{rst_val}};
    end else begin
      ff <= {ff[depth-2:0], d};
    end
  end

  assign q = ff[depth-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: deserialises rxi into bitwidth-bit words.
// Optional macro UART_RX_MAJORITY_EN: take every sample as a 2-of-3 vote
// over the last three synchronized line values.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned bitwidth = 8,
  parameter int unsigned divisor  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rxi,
  output logic [bitwidth-1:0] data,
  output logic                valid,
  output logic                ferr,
  output logic                busy
);

  localparam int unsigned cnt_w = $clog2(divisor);
  localparam int unsigned bit_w = $clog2(bitwidth + 1);
  localparam int unsigned half  = uart_half(divisor);

  localparam logic [2:0] S_ARM   = ARM;
  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_START = START;
  localparam logic [2:0] S_DATA  = DATA;
  localparam logic [2:0] S_STOP  = STOP;

  if (divisor < 8) begin : g_divisor_check
    $error("uart_rx: divisor must be at least 8");
  end

  logic                rxs;
  logic                sample_c;
  logic [2:0]          state, state_n;
  logic [cnt_w-1:0]    cnt, cnt_n;
  logic [bit_w-1:0]    bit_idx, bit_idx_n;
  logic [bitwidth-1:0] sreg, sreg_n;
  logic [bitwidth-1:0] data_n;
  logic                valid_n, ferr_n, busy_n;

  uart_sync #(
    .depth   (2),
    .rst_val (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxi),
    .q   (rxs)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two previous rxs values; with the current rxs they form the 3-sample vote.
  logic [1:0] hist;

  // History of the synchronized line, idle level after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rxs};
    end
  end

  assign sample_c = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample_c = rxs;
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_ARM;
      cnt     <= '0;
      bit_idx <= '0;
      sreg    <= '0;
      data    <= '0;
      valid   <= 1'b0;
      ferr    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      sreg    <= sreg_n;
      data    <= data_n;
      valid   <= valid_n;
      ferr    <= ferr_n;
      busy    <= busy_n;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    sreg_n    = sreg;
    data_n    = data;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;

    case (state)
      S_ARM: begin
        // Wait for the line to be high so a held-low line is not a start bit.
        if (rxs) begin
          state_n = S_IDLE;
        end
      end
      S_IDLE: begin
        if (!rxs) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end
      S_START: begin
        if (cnt == cnt_w'(half - 1)) begin
          if (!sample_c) begin
            state_n   = S_DATA;
            cnt_n     = '0;
            bit_idx_n = '0;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + cnt_w'(1);
        end
      end
      S_DATA: begin
        if (cnt == cnt_w'(divisor - 1)) begin
          // LSB arrives first, so shift in from the top.
          sreg_n    = bitwidth'({sample_c, sreg} >> 1);
          cnt_n     = '0;
          bit_idx_n = bit_idx + bit_w'(1);
          if (bit_idx == bit_w'(bitwidth - 1)) begin
            state_n = S_STOP;
          end
        end else begin
          cnt_n = cnt + cnt_w'(1);
        end
      end
      S_STOP: begin
        if (cnt == cnt_w'(divisor - 1)) begin
          if (sample_c) begin
            data_n  = sreg;
            valid_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_ARM;
          end
        end else begin
          cnt_n = cnt + cnt_w'(1);
        end
      end
      default: begin
        state_n = S_ARM;
      end
    endcase

    busy_n = (state_n == S_START) || (state_n == S_DATA) || (state_n == S_STOP);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx (bitwidth 8, divisor 16).
module tb_uart_rx;

  localparam int unsigned BW   = 8;
  localparam int unsigned DIV  = 16;
  localparam int unsigned HALF = DIV / 2;
  // Falling edge of rxi to the cycle in which valid/ferr is seen.
  localparam int unsigned LAT  = 3 + HALF + (BW + 1) * DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxi;
  logic [BW-1:0] data;
  logic          valid;
  logic          ferr;
  logic          busy;

  uart_rx #(.bitwidth(BW), .divisor(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxi   (rxi),
    .data  (data),
    .valid (valid),
    .ferr  (ferr),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_err;
    logic [BW-1:0] d;
    int unsigned   at;
  } exp_t;

  exp_t          expq[$];
  logic [BW-1:0] good = '0;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    rxi = 1'b1;
    repeat (n) tick();
  endtask

  // Drive one frame; expectation comes from the frame content and line timing.
  task automatic send_frame(input logic [BW-1:0] d, input bit stop, input bit spike,
                            input int unsigned tail_low);
    exp_t        e;
    int unsigned c;
    logic [BW-1:0] w;
    bit          any_busy;
    c = cyc;
    w = d;
`ifndef UART_RX_MAJORITY_EN
    if (spike) w = ~d;
`endif
    e.at = c + LAT;
    if (stop) begin
      e.is_err = 1'b0;
      e.d      = w;
      good     = w;
    end else begin
      e.is_err = 1'b1;
      e.d      = good;
    end
    expq.push_back(e);

    rxi = 1'b0;
    for (int j = 0; j < int'(DIV); j++) begin
      if (j == 2) chk("busy_before_T", 32'(busy), 32'd0);
      if (j == 3) chk("busy_rise", 32'(busy), 32'd1);
      tick();
    end
    for (int k = 0; k < int'(BW); k++) begin
      for (int j = 0; j < int'(DIV); j++) begin
        rxi = (spike && j == int'(HALF)) ? ~d[k] : d[k];
        if (k == 4 && j == 0) chk("busy_mid", 32'(busy), 32'd1);
        tick();
      end
    end
    rxi = stop;
    repeat (DIV) tick();
    if (tail_low > 0) begin
      any_busy = 1'b0;
      rxi = 1'b0;
      repeat (tail_low) begin
        any_busy |= busy;
        tick();
      end
      chk("arm_quiet_busy", 32'(any_busy), 32'd0);
    end
  endtask

  // Monitor: every valid/ferr pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (valid || ferr)) begin
      if (valid && ferr) chk("valid_and_ferr", 32'({valid, ferr}), 32'b10);
      if (expq.size() == 0) begin
        chk("unexpected_pulse", 32'({valid, ferr}), 32'd0);
      end else begin
        e = expq.pop_front();
        chk("pulse_kind", 32'(ferr), 32'(e.is_err));
        chk("data", 32'(data), 32'(e.d));
        chk("pulse_time", cyc, e.at);
        chk("busy_fall", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    int unsigned c;
    rst = 1'b1;
    rxi = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", 32'({data, valid, ferr, busy}), 32'd0);
    rst = 1'b0;
    idle(10);

    // Single frame.
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    idle(20);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 0);
    idle(20);

    // Short low glitch on the idle line.
    c = cyc;
    rxi = 1'b0;
    repeat (4) tick();
    rxi = 1'b1;
    tick();
    chk("glitch_busy_high", 32'(busy), 32'd1);
    repeat (30) tick();
    chk("glitch_busy_low", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    idle(20);

    // Framing error, line held low, then recovery.
    send_frame(8'h00, 1'b0, 1'b0, 400);
    idle(20);
    send_frame(8'h81, 1'b1, 1'b0, 0);
    idle(20);

    // Reset during data bit 3 of 0x5A, line low at release.
    begin
      logic [BW-1:0] d;
      d = 8'h5A;
      rxi = 1'b0;
      repeat (DIV) tick();
      for (int k = 0; k < 3; k++) begin
        rxi = d[k];
        repeat (DIV) tick();
      end
      rxi = d[3];
      repeat (5) tick();
      rst = 1'b1;
      rxi = 1'b0;
      repeat (4) tick();
      rst = 1'b0;
      good = '0;
      tick();
      chk("reset_mid_outputs", 32'({data, valid, ferr, busy}), 32'd0);
      repeat (2) tick();
      idle(40);
      chk("reset_mid_data_held", 32'(data), 32'd0);
    end
    send_frame(8'hC3, 1'b1, 1'b0, 0);
    idle(20);

    // Spike at every data-bit decision edge.
    send_frame(8'h55, 1'b1, 1'b1, 0);
    idle(20);

    // Random frames with random gaps, occasional framing errors.
    for (int i = 0; i < 14; i++) begin
      logic [BW-1:0] d;
      bit            stop;
      d    = BW'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop, 1'b0, 0);
      if (stop) idle($urandom_range(0, 10));
      else      idle($urandom_range(2, 10));
    end

    idle(200);
    if (expq.size() != 0) chk("missing_pulses", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
